// File: rtl/comparison_pkg.sv
// ---------------------------------------------------------------------------
// comparison_pkg
// Shared definitions for the multicycle comparison unit:
//   - op-code encodings carried on alu_op_select
//   - FSM state encoding
//   - helpers that classify an op-code and map (eq, lt) to the op outcome
// ---------------------------------------------------------------------------
package comparison_pkg;

  localparam logic [3:0] IS_EQ  = 4'b0000;
  localparam logic [3:0] IS_NE  = 4'b0001;
  localparam logic [3:0] IS_GE  = 4'b0010;
  localparam logic [3:0] IS_GEU = 4'b0110;
  localparam logic [3:0] IS_LT  = 4'b0011;
  localparam logic [3:0] IS_LTU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed relations are the only ones that need the MSB chunk re-biased.
  function automatic logic is_signed(input logic [3:0] op);
    return (op == IS_GE) || (op == IS_LT);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == IS_EQ) || (op == IS_NE) || (op == IS_GE) ||
           (op == IS_GEU) || (op == IS_LT) || (op == IS_LTU);
  endfunction

  // Map the final operand relation onto the requested comparison.
  function automatic logic op_outcome(input logic [3:0] op,
                                      input logic eq,
                                      input logic lt);
    logic r;
    r = 1'b0;
    case (op)
      IS_EQ:          r = eq;
      IS_NE:          r = !eq;
      IS_LT, IS_LTU:  r = lt;
      IS_GE, IS_GEU:  r = !lt;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chunk_comparator.sv
// ---------------------------------------------------------------------------
// chunk_comparator
// Purely combinational compare of one CHUNK_WIDTH slice.
// Ports:
//   a, b        chunk of operand 1 / operand 2
//   invert_msb  flip the top bit of both inputs before comparing; turns an
//               unsigned compare into a two's-complement compare for the
//               most significant chunk of a signed operation
//   eq          a == b
//   lt          a < b (unsigned, after the optional MSB flip)
// ---------------------------------------------------------------------------
module chunk_comparator #(
  parameter int CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   invert_msb,
  output logic                   eq,
  output logic                   lt
);

  logic [CHUNK_WIDTH-1:0] flip;

  // Built bit-wise so CHUNK_WIDTH==1 needs no zero-width replication.
  always_comb begin
    flip = '0;
    flip[CHUNK_WIDTH-1] = invert_msb;
  end

  // Equality is unaffected by flipping the same bit on both sides.
  assign eq = (a == b);
  assign lt = ((a ^ flip) < (b ^ flip));

endmodule

// File: rtl/multicycle_comparison_unit.sv
// ---------------------------------------------------------------------------
// multicycle_comparison_unit
// Evaluates EQ/NE/GE/GEU/LT/LTU over OPD_LENGTH-bit operands one
// CHUNK_WIDTH slice per cycle, most significant slice first.
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   in_valid / in_ready     request handshake; opd1, opd2, alu_op_select
//                           are captured when both are high
//   out_valid / out_ready   result handshake; comp_result[0] is the outcome,
//                           upper bits are zero, value holds between results
// Parameters:
//   OPD_LENGTH   operand / result width
//   CHUNK_WIDTH  bits examined per cycle (must divide OPD_LENGTH)
//   EARLY_EXIT   1: finish at the first differing chunk
//                0: always walk every chunk (fixed latency)
// ---------------------------------------------------------------------------
module multicycle_comparison_unit
  import comparison_pkg::*;
#(
  parameter int OPD_LENGTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int EARLY_EXIT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPD_LENGTH-1:0] opd1,
  input  logic [OPD_LENGTH-1:0] opd2,
  input  logic [3:0]            alu_op_select,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPD_LENGTH-1:0] comp_result
);

  localparam int NUM_CHUNKS = OPD_LENGTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t                state_reg, state_next;
  logic [OPD_LENGTH-1:0] opd1_reg, opd2_reg, comp_result_reg;
  logic [3:0]            op_reg;
  logic [IDX_W-1:0]      idx_reg;
  // First (most significant) difference found so far; only meaningful when
  // the walk continues past it, i.e. EARLY_EXIT=0.
  logic                  diff_seen_reg;
  logic                  diff_lt_reg;

  logic [CHUNK_WIDTH-1:0] chunk1 [NUM_CHUNKS];
  logic [CHUNK_WIDTH-1:0] chunk2 [NUM_CHUNKS];
  logic [CHUNK_WIDTH-1:0] cur1, cur2;
  logic                   chunk_eq, chunk_lt, invert_msb;
  logic                   op_legal, scan_finish;
  logic                   final_eq, final_lt, outcome;

  // Slice the captured operands so the active chunk is a simple array read.
  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_slice
      assign chunk1[gi] = opd1_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
      assign chunk2[gi] = opd2_reg[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    end
  endgenerate

  assign cur1       = chunk1[idx_reg];
  assign cur2       = chunk2[idx_reg];
  assign invert_msb = is_signed(op_reg) && (idx_reg == LAST_IDX);

  chunk_comparator #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_chunk (
    .a          (cur1),
    .b          (cur2),
    .invert_msb (invert_msb),
    .eq         (chunk_eq),
    .lt         (chunk_lt)
  );

  assign op_legal = is_legal(op_reg);

  // An illegal op spends one cycle in SCAN and retires with 0, so it has
  // the same one-cycle latency as a decision on the MSB chunk.
  assign scan_finish = !op_legal || (idx_reg == '0) ||
                       ((EARLY_EXIT != 0) && !chunk_eq);

  always_comb begin
    final_eq = diff_seen_reg ? 1'b0 : chunk_eq;
    final_lt = diff_seen_reg ? diff_lt_reg : chunk_lt;
    outcome  = op_legal && op_outcome(op_reg, final_eq, final_lt);
  end

  // --- FSM: state register ---
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // --- FSM: next-state logic ---
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)    state_next = SCAN;
      SCAN:    if (scan_finish) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // --- FSM: outputs ---
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  assign comp_result = comp_result_reg;

  // --- Datapath registers ---
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opd1_reg        <= '0;
      opd2_reg        <= '0;
      op_reg          <= '0;
      idx_reg         <= '0;
      diff_seen_reg   <= 1'b0;
      diff_lt_reg     <= 1'b0;
      comp_result_reg <= '0;
    end else begin
      if (state_reg == IDLE && in_valid) begin
        opd1_reg      <= opd1;
        opd2_reg      <= opd2;
        op_reg        <= alu_op_select;
        idx_reg       <= LAST_IDX;
        diff_seen_reg <= 1'b0;
        diff_lt_reg   <= 1'b0;
      end
      if (state_reg == SCAN) begin
        if (!chunk_eq && !diff_seen_reg) begin
          diff_seen_reg <= 1'b1;
          diff_lt_reg   <= chunk_lt;
        end
        if (scan_finish) comp_result_reg <= OPD_LENGTH'(outcome);
        else             idx_reg         <= idx_reg - 1'b1;
      end
    end
  end

endmodule
